wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, consecutive pipeline-won cycles with a secondary request pending before the pipeline is forced to hold.
REQ-002 clk  input  1  single core clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 wb_we_i  input  1  pipeline writeback GPR write enable.
REQ-005 wb_waddr_i  input  5  pipeline GPR write address.
REQ-006 wb_wdata_i  input  32  pipeline GPR write data.
REQ-007 div_req_i  input  1  divider result write request.
REQ-008 div_waddr_i  input  5  divider destination register.
REQ-009 div_wdata_i  input  32  divider result.
REQ-010 div_ack_o  output  1  divider request granted this cycle.
REQ-011 lsu_req_i  input  1  late-load write request.
REQ-012 lsu_waddr_i  input  5  load destination register.
REQ-013 lsu_wdata_i  input  32  load data.
REQ-014 lsu_ack_o  output  1  load request granted this cycle.
REQ-015 rf_we_o  output  1  registered GPR write enable to the register file.
REQ-016 rf_waddr_o  output  5  registered GPR write address.
REQ-017 rf_wdata_o  output  32  registered GPR write data.
REQ-018 hold_flag_o  output  1  registered stall request to the pipeline (freezes the writeback stage).

Function
REQ-019 The register file has one write port; the block SHALL grant at most one source per cycle and drive rf_* on the following clock edge (latency 1).
REQ-020 Secondary handshake: req/waddr/wdata held stable until ack; ack is a combinational single-cycle pulse in the grant cycle; the requester may drop or change req the cycle after ack.
REQ-021 FSM states ARB and FORCE.
REQ-022 In ARB, if wb_we_i=1, the pipeline SHALL win; otherwise the secondaries SHALL be served round-robin: the source not granted last wins on contention, a lone requester wins immediately.
REQ-023 Starvation counter: increments when the pipeline wins in ARB while div_req_i or lsu_req_i is 1; clears when a secondary is granted or no secondary is pending; saturates at STARVE_LIMIT.
REQ-024 ARB->FORCE when the counter would reach STARVE_LIMIT; hold_flag_o=1 exactly during FORCE.
REQ-025 In FORCE, wb_* inputs SHALL be ignored (the pipeline re-presents them); the round-robin secondary winner SHALL be granted; FORCE->ARB after one cycle unconditionally; counter cleared.
REQ-026 If FORCE is entered and no secondary is pending (requester dropped illegally), no write and no ack in that cycle; return to ARB.
REQ-027 Writes to x0 (address 0) SHALL be granted/acked normally, but rf_we_o SHALL stay 0.
REQ-028 No grant in a cycle -> rf_we_o=0 next cycle; rf_waddr_o/rf_wdata_o SHALL then be 0.
REQ-029 Same-destination ordering between pipeline and secondaries is not checked here; the issue-stage scoreboard prevents it.

Reset
REQ-030 Asserting rst at any time SHALL immediately force rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, hold_flag_o=0, acks=0, state=ARB, counter=0, last-grant=lsu (div wins first contention).
REQ-031 Requests in flight at reset are discarded; requesters SHALL re-issue after reset release.

Structure
REQ-032 Bus widths (RegAddrBus, RegBus), ZeroReg, WriteEnable/WriteDisable, HoldEnable/HoldDisable constants SHALL come from the shared defines.v.
REQ-033 The 2-way round-robin with last-grant register SHALL be a sub-module wb_rr_arb2.

Verification
REQ-034 wb_we_i=1 x5 -> rf_we_o=1, waddr=5, wdata=0x11 one cycle after each; hold never set.
REQ-035 div_req_i and lsu_req_i both 1 from reset, no pipeline -> div_ack_o first cycle, lsu_ack_o next; rf writes div then lsu on consecutive cycles.
REQ-036 wb_we_i held 1, div_req_i=1, STARVE_LIMIT=4 -> 4 pipeline writes, then hold_flag_o=1 one cycle, div_ack_o in that cycle, div data on rf_* next cycle.
REQ-037 lsu_req_i=1, lsu_waddr_i=0, lsu_wdata_i=0xDEADBEEF -> lsu_ack_o=1, rf_we_o stays 0.
REQ-038 rst pulsed during FORCE -> hold_flag_o, rf_we_o, acks drop to 0 asynchronously; state ARB, counter 0 after release.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared constants and types for the GPR write-port arbiter.
package wb_arbiter_pkg;

   localparam int RegAddrBus = 5;
   localparam int RegBus     = 32;

   localparam logic [RegAddrBus-1:0] ZeroReg      = '0;
   localparam logic                  WriteEnable  = 1'b1;
   localparam logic                  WriteDisable = 1'b0;
   localparam logic                  HoldEnable   = 1'b1;
   localparam logic                  HoldDisable  = 1'b0;

   typedef enum logic {
      ARB   = 1'b0,
      FORCE = 1'b1
   } arb_state_e;

endpackage

// File: rtl/wb_arbiter_rr_arb2.sv
// Two-way round-robin between the divider (a) and late-load (b) requesters.
// Out of reset the last grant is b, so a wins the first contention.
module wb_rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic req_a,
   input  logic req_b,
   output logic gnt_a,
   output logic gnt_b
);

   logic last_b;

   assign gnt_a = en && req_a && (!req_b || last_b);
   assign gnt_b = en && req_b && (!req_a || !last_b);

   // Remember which side was served so the other one wins the next tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        last_b <= 1'b1;
      else if (gnt_a) last_b <= 1'b0;
      else if (gnt_b) last_b <= 1'b1;
   end

endmodule

// File: rtl/wb_arbiter.sv
// Single-write-port GPR arbiter: pipeline writeback has priority, divider and
// late-load results share the leftover slots round-robin. A starvation counter
// forces a one-cycle pipeline hold so a pending secondary always gets through.
//
// state | meaning
// ARB   | pipeline wins when writing, otherwise round-robin secondaries
// FORCE | pipeline held (hold_flag_o=1), secondary winner granted, one cycle
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_we_i,
   input  logic [RegAddrBus-1:0] wb_waddr_i,
   input  logic [RegBus-1:0]     wb_wdata_i,
   input  logic                  div_req_i,
   input  logic [RegAddrBus-1:0] div_waddr_i,
   input  logic [RegBus-1:0]     div_wdata_i,
   output logic                  div_ack_o,
   input  logic                  lsu_req_i,
   input  logic [RegAddrBus-1:0] lsu_waddr_i,
   input  logic [RegBus-1:0]     lsu_wdata_i,
   output logic                  lsu_ack_o,
   output logic                  rf_we_o,
   output logic [RegAddrBus-1:0] rf_waddr_o,
   output logic [RegBus-1:0]     rf_wdata_o,
   output logic                  hold_flag_o
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   arb_state_e            state;
   logic [CNT_W-1:0]      starve_cnt;
   logic                  pipe_win;
   logic                  sec_en;
   logic                  sec_pending;
   logic                  div_gnt;
   logic                  lsu_gnt;
   logic                  sel_valid;
   logic [RegAddrBus-1:0] sel_addr;
   logic [RegBus-1:0]     sel_data;
   logic                  do_write;

   assign sec_pending = div_req_i | lsu_req_i;
   assign pipe_win    = (state == ARB) && wb_we_i;
   // Gating with rst keeps the combinational acks low while reset is asserted.
   assign sec_en      = !rst && !pipe_win;

   wb_rr_arb2 u_rr (
      .clk   (clk),
      .rst   (rst),
      .en    (sec_en),
      .req_a (div_req_i),
      .req_b (lsu_req_i),
      .gnt_a (div_gnt),
      .gnt_b (lsu_gnt)
   );

   assign div_ack_o = div_gnt;
   assign lsu_ack_o = lsu_gnt;

   // Mux the winning source onto the write port.
   always_comb begin
      sel_valid = 1'b0;
      sel_addr  = ZeroReg;
      sel_data  = '0;
      if (pipe_win) begin
         sel_valid = 1'b1;
         sel_addr  = wb_waddr_i;
         sel_data  = wb_wdata_i;
      end else if (div_gnt) begin
         sel_valid = 1'b1;
         sel_addr  = div_waddr_i;
         sel_data  = div_wdata_i;
      end else if (lsu_gnt) begin
         sel_valid = 1'b1;
         sel_addr  = lsu_waddr_i;
         sel_data  = lsu_wdata_i;
      end
   end

   // x0 writes are still granted but never reach the register file.
   assign do_write = sel_valid && (sel_addr != ZeroReg);

   // Register the write port; idle cycles present an all-zero bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we_o    <= WriteDisable;
         rf_waddr_o <= ZeroReg;
         rf_wdata_o <= '0;
      end else if (do_write) begin
         rf_we_o    <= WriteEnable;
         rf_waddr_o <= sel_addr;
         rf_wdata_o <= sel_data;
      end else begin
         rf_we_o    <= WriteDisable;
         rf_waddr_o <= ZeroReg;
         rf_wdata_o <= '0;
      end
   end

   // Arbitration FSM with starvation counter and registered hold request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ARB;
         starve_cnt  <= '0;
         hold_flag_o <= HoldDisable;
      end else begin
         case (state)
            ARB: begin
               if (pipe_win && sec_pending) begin
                  if (starve_cnt >= LIMIT - ONE) begin
                     state       <= FORCE;
                     starve_cnt  <= LIMIT;
                     hold_flag_o <= HoldEnable;
                  end else begin
                     starve_cnt  <= starve_cnt + ONE;
                  end
               end else begin
                  starve_cnt <= '0;
               end
            end
            FORCE: begin
               state       <= ARB;
               starve_cnt  <= '0;
               hold_flag_o <= HoldDisable;
            end
            default: begin
               state       <= ARB;
               starve_cnt  <= '0;
               hold_flag_o <= HoldDisable;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a vector table for the per-cycle behaviour
// plus hand sequences for reset-in-FORCE and a dropped request in FORCE.
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_we_i;
   logic [4:0]  wb_waddr_i;
   logic [31:0] wb_wdata_i;
   logic        div_req_i;
   logic [4:0]  div_waddr_i;
   logic [31:0] div_wdata_i;
   logic        div_ack_o;
   logic        lsu_req_i;
   logic [4:0]  lsu_waddr_i;
   logic [31:0] lsu_wdata_i;
   logic        lsu_ack_o;
   logic        rf_we_o;
   logic [4:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o;
   logic        hold_flag_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .wb_we_i     (wb_we_i),
      .wb_waddr_i  (wb_waddr_i),
      .wb_wdata_i  (wb_wdata_i),
      .div_req_i   (div_req_i),
      .div_waddr_i (div_waddr_i),
      .div_wdata_i (div_wdata_i),
      .div_ack_o   (div_ack_o),
      .lsu_req_i   (lsu_req_i),
      .lsu_waddr_i (lsu_waddr_i),
      .lsu_wdata_i (lsu_wdata_i),
      .lsu_ack_o   (lsu_ack_o),
      .rf_we_o     (rf_we_o),
      .rf_waddr_o  (rf_waddr_o),
      .rf_wdata_o  (rf_wdata_o),
      .hold_flag_o (hold_flag_o)
   );

   typedef struct {
      logic        wb_we;
      logic [4:0]  wb_waddr;
      logic [31:0] wb_wdata;
      logic        div_req;
      logic [4:0]  div_waddr;
      logic [31:0] div_wdata;
      logic        lsu_req;
      logic [4:0]  lsu_waddr;
      logic [31:0] lsu_wdata;
      logic        e_div_ack;
      logic        e_lsu_ack;
      logic        e_we;
      logic [4:0]  e_waddr;
      logic [31:0] e_wdata;
      logic        e_hold;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic dr, input logic [4:0] da, input logic [31:0] dd,
                      input logic lr, input logic [4:0] la, input logic [31:0] ld,
                      input logic eda, input logic ela, input logic ewe,
                      input logic [4:0] ewa, input logic [31:0] ewd, input logic eh);
      vec_t v;
      v.wb_we = we; v.wb_waddr = wa; v.wb_wdata = wd;
      v.div_req = dr; v.div_waddr = da; v.div_wdata = dd;
      v.lsu_req = lr; v.lsu_waddr = la; v.lsu_wdata = ld;
      v.e_div_ack = eda; v.e_lsu_ack = ela; v.e_we = ewe;
      v.e_waddr = ewa; v.e_wdata = ewd; v.e_hold = eh;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic dr, input logic [4:0] da, input logic [31:0] dd,
                        input logic lr, input logic [4:0] la, input logic [31:0] ld);
      wb_we_i = we; wb_waddr_i = wa; wb_wdata_i = wd;
      div_req_i = dr; div_waddr_i = da; div_wdata_i = dd;
      lsu_req_i = lr; lsu_waddr_i = la; lsu_wdata_i = ld;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h0A, 1'b1, 5'd7, 32'h0B);

      // reset state: outputs and acks low even with requests present
      repeat (2) @(posedge clk);
      #1;
      check("rst_we",    32'(rf_we_o),     32'd0);
      check("rst_waddr", 32'(rf_waddr_o),  32'd0);
      check("rst_wdata", rf_wdata_o,       32'd0);
      check("rst_hold",  32'(hold_flag_o), 32'd0);
      check("rst_dack",  32'(div_ack_o),   32'd0);
      check("rst_lack",  32'(lsu_ack_o),   32'd0);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      rst = 1'b0;

      // pipeline-only writes, five in a row
      for (int i = 0; i < 5; i++)
         add(1, 5'd5, 32'h11, 0, 0, 0, 0, 0, 0,   0, 0, 1, 5'd5, 32'h11, 0);
      // idle cycle: zero bus
      add(0, 0, 0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0);
      // contention from fresh last-grant: div first, then lsu
      add(0, 0, 0, 1, 5'd3, 32'hA, 1, 5'd7, 32'hB, 1, 0, 1, 5'd3, 32'hA, 0);
      add(0, 0, 0, 1, 5'd3, 32'hC, 1, 5'd7, 32'hB, 0, 1, 1, 5'd7, 32'hB, 0);
      // lsu write to x0: acked, no write
      add(0, 0, 0, 0, 0, 0, 1, 5'd0, 32'hDEADBEEF, 0, 1, 0, 0, 0, 0);
      // pipeline write to x0: no write
      add(1, 5'd0, 32'h55, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0);
      // contention again: lsu was last, div wins; then lone lsu
      add(0, 0, 0, 1, 5'd3, 32'hC, 1, 5'd8, 32'hD, 1, 0, 1, 5'd3, 32'hC, 0);
      add(0, 0, 0, 0, 0, 0, 1, 5'd8, 32'hD,      0, 1, 1, 5'd8, 32'hD, 0);
      // starvation: four pipeline wins with div pending, then forced slot
      for (int i = 0; i < 3; i++)
         add(1, 5'd9, 32'h99, 1, 5'd4, 32'h44, 0, 0, 0, 0, 0, 1, 5'd9, 32'h99, 0);
      add(1, 5'd9, 32'h99, 1, 5'd4, 32'h44, 0, 0, 0, 0, 0, 1, 5'd9, 32'h99, 1);
      add(1, 5'd9, 32'h99, 1, 5'd4, 32'h44, 0, 0, 0, 1, 0, 1, 5'd4, 32'h44, 0);
      add(1, 5'd9, 32'h99, 0, 0, 0, 0, 0, 0,     0, 0, 1, 5'd9, 32'h99, 0);
      // counter clears on a secondary grant: three wins, grant, three more wins
      for (int i = 0; i < 3; i++)
         add(1, 5'd6, 32'h66, 1, 5'd2, 32'h22, 0, 0, 0, 0, 0, 1, 5'd6, 32'h66, 0);
      add(0, 0, 0, 1, 5'd2, 32'h22, 0, 0, 0,     1, 0, 1, 5'd2, 32'h22, 0);
      for (int i = 0; i < 3; i++)
         add(1, 5'd6, 32'h66, 1, 5'd2, 32'h23, 0, 0, 0, 0, 0, 1, 5'd6, 32'h66, 0);
      add(0, 0, 0, 1, 5'd2, 32'h23, 0, 0, 0,     1, 0, 1, 5'd2, 32'h23, 0);

      @(posedge clk);
      #1;
      foreach (vecs[k]) begin
         drive(vecs[k].wb_we, vecs[k].wb_waddr, vecs[k].wb_wdata,
               vecs[k].div_req, vecs[k].div_waddr, vecs[k].div_wdata,
               vecs[k].lsu_req, vecs[k].lsu_waddr, vecs[k].lsu_wdata);
         #1;
         check($sformatf("v%0d_dack", k), 32'(div_ack_o), 32'(vecs[k].e_div_ack));
         check($sformatf("v%0d_lack", k), 32'(lsu_ack_o), 32'(vecs[k].e_lsu_ack));
         @(posedge clk);
         #1;
         check($sformatf("v%0d_we", k),    32'(rf_we_o),     32'(vecs[k].e_we));
         check($sformatf("v%0d_waddr", k), 32'(rf_waddr_o),  32'(vecs[k].e_waddr));
         check($sformatf("v%0d_wdata", k), rf_wdata_o,       vecs[k].e_wdata);
         check($sformatf("v%0d_hold", k),  32'(hold_flag_o), 32'(vecs[k].e_hold));
      end

      // reset pulsed while in FORCE
      drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0);
      repeat (4) @(posedge clk);
      #1;
      check("frc_hold", 32'(hold_flag_o), 32'd1);
      check("frc_dack", 32'(div_ack_o),   32'd1);
      check("frc_we",   32'(rf_we_o),     32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_hold", 32'(hold_flag_o), 32'd0);
      check("arst_we",   32'(rf_we_o),     32'd0);
      check("arst_dack", 32'(div_ack_o),   32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      // counter must restart from zero: 3 wins no hold, 4th raises hold
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("post_rst_hold%0d", i), 32'(hold_flag_o), (i == 3) ? 32'd1 : 32'd0);
      end
      // in FORCE with the requester dropped: no ack, no write
      drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      #1;
      check("drop_dack", 32'(div_ack_o), 32'd0);
      check("drop_lack", 32'(lsu_ack_o), 32'd0);
      @(posedge clk);
      #1;
      check("drop_we",   32'(rf_we_o),     32'd0);
      check("drop_hold", 32'(hold_flag_o), 32'd0);
      // last-grant reset to lsu: div wins the first contention after reset
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h1234, 1'b1, 5'd13, 32'h5678);
      #1;
      check("post_rst_dack", 32'(div_ack_o), 32'd1);
      check("post_rst_lack", 32'(lsu_ack_o), 32'd0);
      @(posedge clk);
      #1;
      check("post_rst_waddr", 32'(rf_waddr_o), 32'd12);
      check("post_rst_wdata", rf_wdata_o,      32'h1234);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
